// File: rtl/rca_nibble_sequencer.sv
// Wide add/subtract built from one shared 4-bit ripple-carry adder, stepped
// one nibble per cycle from least significant upward with a registered carry.

module ripple_carry_adder (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [4:0] carry;

   assign carry[0] = cin;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
   end

   assign cout = carry[4];

endmodule

module rca_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   sub,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   output logic                   ready,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
   output logic                   overflow
);

   localparam int IDX_W = $clog2(NIBBLES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   logic [1:0]                state_q, state_d;
   logic [NIBBLES-1:0][3:0]   a_r_q, a_r_d;
   logic [NIBBLES-1:0][3:0]   b_r_q, b_r_d;
   logic                      c_r_q, c_r_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [NIBBLES-1:0][3:0]   acc_q, acc_d;
   logic [4*NIBBLES-1:0]      result_q, result_d;
   logic                      cout_q, cout_d;
   logic                      overflow_q, overflow_d;

   logic [3:0] a_nib;
   logic [3:0] b_nib;
   logic [3:0] sum_nib;
   logic       add_cout;
   logic       sign_a;
   logic       sign_b;

   assign a_nib  = a_r_q[idx_q];
   assign b_nib  = b_r_q[idx_q];
   assign sign_a = a_r_q[NIBBLES-1][3];
   // B is already inverted for subtract, so the add-style overflow rule covers both.
   assign sign_b = b_r_q[NIBBLES-1][3];

   ripple_carry_adder u_rca (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (c_r_q),
      .sum  (sum_nib),
      .cout (add_cout)
   );

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d    = state_q;
      a_r_d      = a_r_q;
      b_r_d      = b_r_q;
      c_r_d      = c_r_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      result_d   = result_q;
      cout_d     = cout_q;
      overflow_d = overflow_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_r_d   = a;
               b_r_d   = sub ? ~b : b;
               c_r_d   = sub;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d[idx_q] = sum_nib;
            c_r_d        = add_cout;
            if (idx_q == IDX_LAST) begin
               result_d   = acc_d;
               cout_d     = add_cout;
               overflow_d = (sign_a == sign_b) && (sum_nib[3] != sign_a);
               state_d    = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; always_comb above uses blocking.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         c_r_q      <= 1'b0;
         idx_q      <= '0;
         acc_q      <= '0;
         result_q   <= '0;
         cout_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         c_r_q      <= c_r_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
         cout_q     <= cout_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: operand registers carry no reset; they are always loaded before being read.
   always_ff @(posedge clk) begin
      a_r_q <= a_r_d;
      b_r_q <= b_r_d;
   end

   assign ready    = (state_q == S_IDLE);
   assign busy     = (state_q == S_RUN);
   assign done     = (state_q == S_DONE);
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_rca_nibble_sequencer.sv
// Scoreboarded bench: the driver queues expected results from an arithmetic
// model, and a negedge monitor pops and compares on every done pulse.

module tb_rca_nibble_sequencer;

   localparam int NIBBLES = 4;
   localparam int W       = 4 * NIBBLES;

   typedef struct packed {
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         ready;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];
   exp_t held;
   logic rst_prev = 1'b0;
   bit   mon_en   = 1'b0;

   rca_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rst_prev <= rst_n;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reference: plain W-bit arithmetic, unsigned compare for borrow, sign rules for overflow.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      exp_t       e;
      logic [W:0] wide;
      if (!s) begin
         wide  = {1'b0, x} + {1'b0, y};
         e.res = wide[W-1:0];
         e.cout = wide[W];
         e.ovf = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
      end else begin
         e.res = x - y;
         e.cout = (x >= y);
         e.ovf = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      return e;
   endfunction

   function automatic logic [W-1:0] rand_w();
      logic [W-1:0] v;
      for (int i = 0; i < NIBBLES; i++) v[4*i +: 4] = 4'($urandom());
      return v;
   endfunction

   // Monitor: reset values after a reset edge, scoreboard pop on done, hold otherwise.
   initial begin
      exp_t e;
      held = '0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (!rst_prev) begin
               exp_q.delete();
               held = '0;
               check("rst_result", result, '0);
               check("rst_cout", W'(cout), '0);
               check("rst_overflow", W'(overflow), '0);
               check("rst_ready", W'(ready), W'(1));
               check("rst_busy", W'(busy), '0);
               check("rst_done", W'(done), '0);
            end else if (done) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_done", W'(done), '0);
               end else begin
                  e = exp_q.pop_front();
                  check("result", result, e.res);
                  check("cout", W'(cout), W'(e.cout));
                  check("overflow", W'(overflow), W'(e.ovf));
                  held = e;
               end
            end else begin
               check("result_hold", result, held.res);
               check("cout_hold", W'(cout), W'(held.cout));
               check("overflow_hold", W'(overflow), W'(held.ovf));
            end
         end
      end
   end

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         input exp_t e, input bit pulse);
      check("ready_idle", W'(ready), W'(1));
      a = x; b = y; sub = s; start = 1'b1;
      exp_q.push_back(e);
      tick();
      start = 1'b0; a = rand_w(); b = rand_w(); sub = 1'($urandom());
      for (int k = 0; k < NIBBLES; k++) begin
         check("busy_run", W'(busy), W'(1));
         check("ready_run", W'(ready), '0);
         check("done_run", W'(done), '0);
         start = (pulse && k == 1);
         if (pulse && k == 1) a = '1;
         tick();
      end
      check("done_pulse", W'(done), W'(1));
      check("busy_done", W'(busy), '0);
      check("ready_done", W'(ready), '0);
      start = pulse;
      tick();
      start = 1'b0;
      check("done_fall", W'(done), '0);
      check("ready_back", W'(ready), W'(1));
   endtask

   task automatic run_b2b(input logic [W-1:0] x1, input logic [W-1:0] y1, input logic s1,
                          input logic [W-1:0] x2, input logic [W-1:0] y2, input logic s2);
      check("b2b_ready_idle", W'(ready), W'(1));
      a = x1; b = y1; sub = s1; start = 1'b1;
      exp_q.push_back(model(x1, y1, s1));
      tick();
      a = x2; b = y2; sub = s2;
      exp_q.push_back(model(x2, y2, s2));
      for (int k = 0; k < NIBBLES; k++) begin
         check("b2b_busy1", W'(busy), W'(1));
         tick();
      end
      check("b2b_done1", W'(done), W'(1));
      tick();
      check("b2b_ready_gap", W'(ready), W'(1));
      check("b2b_done_fall", W'(done), '0);
      tick();
      start = 1'b0; a = rand_w(); b = rand_w();
      for (int k = 0; k < NIBBLES; k++) begin
         check("b2b_busy2", W'(busy), W'(1));
         tick();
      end
      check("b2b_done2", W'(done), W'(1));
      tick();
      check("b2b_ready_end", W'(ready), W'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: no completion within time limit");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         s;
      rst_n = 1'b0;
      @(posedge clk);
      mon_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      run_op(16'hFFFF, 16'h0001, 1'b0, '{res: 16'h0000, cout: 1'b1, ovf: 1'b0}, 1'b0);
      run_op(16'h1234, 16'h0FFF, 1'b0, '{res: 16'h2233, cout: 1'b0, ovf: 1'b0}, 1'b0);
      run_op(16'h7FFF, 16'h0001, 1'b0, '{res: 16'h8000, cout: 1'b0, ovf: 1'b1}, 1'b0);
      run_op(16'h0005, 16'h0007, 1'b1, '{res: 16'hFFFE, cout: 1'b0, ovf: 1'b0}, 1'b0);
      run_op(16'h8000, 16'h0001, 1'b1, '{res: 16'h7FFF, cout: 1'b1, ovf: 1'b1}, 1'b0);
      run_op(16'h1111, 16'h2222, 1'b0, '{res: 16'h3333, cout: 1'b0, ovf: 1'b0}, 1'b1);
      run_b2b(16'h1234, 16'h4321, 1'b0, 16'h0010, 16'h0020, 1'b1);

      // Abort: reset lands on the second RUN edge.
      a = 16'h1234; b = 16'h5678; sub = 1'b0; start = 1'b1;
      exp_q.push_back(model(16'h1234, 16'h5678, 1'b0));
      tick();
      start = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < NIBBLES + 4; k++) begin
         check("no_done_after_abort", W'(done), '0);
         tick();
      end
      run_op(16'h0101, 16'h0202, 1'b0, '{res: 16'h0303, cout: 1'b0, ovf: 1'b0}, 1'b0);

      for (int i = 0; i < 40; i++) begin
         x = rand_w(); y = rand_w(); s = 1'($urandom());
         if (i % 8 == 0) y = x;
         run_op(x, y, s, model(x, y, s), 1'($urandom()));
      end
      for (int i = 0; i < 4; i++) begin
         run_b2b(rand_w(), rand_w(), 1'($urandom()), rand_w(), rand_w(), 1'($urandom()));
      end

      tick();
      tick();
      check("queue_empty", W'(exp_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rca_nibble_sequencer.md
# rca_nibble_sequencer

Multi-cycle wide adder/subtractor that time-multiplexes a single 4-bit `ripple_carry_adder` instance across `NIBBLES` nibbles, least-significant first, chaining the carry through a register between cycles. It sits between a requesting controller (start/ready/done handshake) and the shared 4-bit adder datapath. Wide add/subtract runs at one nibble per cycle instead of needing a wide combinational adder.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; data width W = 4*NIBBLES; minimum 2.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: synchronous reset, active-low; sampled on rising edge of `clk`.
- `start` input 1: request; accepted only when `ready`=1.
- `sub` input 1: 0 = A+B, 1 = A−B; sampled with `start`.
- `a` input W: operand A; sampled with `start`.
- `b` input W: operand B; sampled with `start`.
- `ready` output 1: high in IDLE only.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse; result valid.
- `result` output W: registered sum/difference; held until next completion.
- `cout` output 1: final carry out of MSB nibble (for subtract, 1 = no borrow).
- `overflow` output 1: two's-complement signed overflow of the W-bit operation.

## Operation
- Internal: 4-bit adder instance, operand registers A_r and B_r (W bits), carry register c_r, nibble index idx (clog2(NIBBLES) bits), accumulation register acc (W bits).
- FSM states: IDLE, RUN, DONE.
- IDLE: `ready`=1. On `start`=1: A_r←a; B_r←(sub ? ~b : b); c_r←sub; idx←0; go to RUN. If `start`=0, stay in IDLE.
- RUN: `busy`=1. The adder receives A_r[4*idx+:4], B_r[4*idx+:4] and c_r. acc[4*idx+:4]←sum and c_r←adder cout.
  - If idx<NIBBLES−1: idx←idx+1.
  - If idx=NIBBLES−1: result←{sum, acc lower bits}; `cout`←adder cout; `overflow`←(A_r[W−1]==B_r[W−1]) && (sum[3]!=A_r[W−1]); go to DONE.
- DONE: `done`=1 for exactly this cycle. Unconditionally go to IDLE.
- `start` is ignored in RUN and DONE. It is neither queued nor sticky.
- `result`, `cout` and `overflow` change only on the final RUN cycle. Partial sums are never visible on `result`.
- Arithmetic is modulo 2^W. Subtraction is A + ~B + 1, which gives unsigned borrow = ~`cout`.

## Timing
- Reset (`rst_n`=0 at a rising edge): state←IDLE; `ready`=1; `busy`=0; `done`=0; `result`=0; `cout`=0; `overflow`=0; idx=0; c_r=0; acc=0.
- Reset asserted mid-RUN or in DONE aborts the operation. No `done` pulse is produced, and the outputs take their reset values.
- Latency: with `start` accepted at edge T0, RUN occupies edges T1..T_NIBBLES. `result` is updated and `done` goes high after edge T_NIBBLES. `done` falls after edge T_NIBBLES+1.
- Throughput: one operation per NIBBLES+2 cycles. `ready` rises in the cycle after `done`, and a `start` held high is accepted there.
- The carry path per cycle is a single 4-bit ripple.

## Test plan
- Reset then idle: `rst_n`=0 for 2 cycles, then `rst_n`=1 -> `ready`=1, `busy`=0, `done`=0, `result`=0x0000, `cout`=0, `overflow`=0.
- Add with carry propagation (NIBBLES=4): a=0xFFFF, b=0x0001, sub=0 -> `done` pulse exactly 4 cycles after the start edge; `result`=0x0000, `cout`=1, `overflow`=0.
- Add mixed: a=0x1234, b=0x0FFF, sub=0 -> `result`=0x2233, `cout`=0, `overflow`=0. Also a=0x7FFF, b=0x0001 -> `result`=0x8000, `cout`=0, `overflow`=1.
- Subtract: a=0x0005, b=0x0007, sub=1 -> `result`=0xFFFE, `cout`=0 (borrow), `overflow`=0. Also a=0x8000, b=0x0001, sub=1 -> `result`=0x7FFF, `cout`=1, `overflow`=1.
- Handshake: pulse `start` with a=0x1111, b=0x2222, then pulse `start` again in RUN with a=0xFFFF -> single `done` with `result`=0x3333. `ready`=0 throughout RUN/DONE; `start` held high back-to-back -> second operation accepted the cycle after `done`.
- Reset mid-operation: assert `rst_n`=0 at the second RUN edge -> no `done`; all outputs return to reset values. A new operation afterwards (0x0101+0x0202) -> `result`=0x0303.
